id_ex_hazard_reg: RTL and testbench

- ID/EX pipeline register with integrated load-use hazard detection, branch flush and data-memory freeze handling.
- Sits between decode and execute; its registered rs/rt/dest/regwrite fields are the operands consumed by the EX-stage forwarding unit.
- Drives stall/flush back to PC and IF/ID, and inserts bubbles so forwarding never sees a squashed instruction.

---
 rtl/id_ex_hazard_reg_pkg.sv | 28 ++
 rtl/id_ex_hazard_reg_if.sv | 58 +++++
 rtl/id_ex_hazard_reg_load_use_detect.sv | 30 +++
 rtl/id_ex_hazard_reg.sv | 162 ++++++++++++++++
 tb/tb_id_ex_hazard_reg.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_hazard_reg_pkg.sv
// Shared types/constants for the ID/EX register: defaults, FSM encoding, bubble control word.
// Pure declarations; no timing or flow control of its own.
package id_ex_hazard_reg_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int REG_AW_DEF = 4;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    typedef struct packed {
        logic valid;
        logic regwrite;
        logic memread;
        logic memwrite;
    } ctrl_t;

    localparam ctrl_t BUBBLE_CTRL = 4'b0000;

    localparam logic [REG_AW_DEF-1:0] ZERO_REG = '0;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/id_ex_hazard_reg_if.sv
// Decode-side and execute-side bundle of the ID/EX register; master = pipeline around it, slave = the register.
// Combinational signal bundle; stall/flush returned on the same interface.
interface id_ex_hazard_reg_if
    import id_ex_hazard_reg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF
) ();

    logic              id_valid;
    logic [REG_AW-1:0] id_regrs;
    logic [REG_AW-1:0] id_regrt;
    logic [REG_AW-1:0] id_regdest;
    logic              id_rs_used;
    logic              id_rt_used;
    logic              id_regwrite;
    logic              id_memread;
    logic              id_memwrite;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [DATA_W-1:0] id_imm;
    logic              ex_flush;
    logic              mem_busy;

    logic              id_ex_valid;
    logic              id_ex_regwrite;
    logic              id_ex_memread;
    logic              id_ex_memwrite;
    logic [REG_AW-1:0] id_ex_regrs;
    logic [REG_AW-1:0] id_ex_regrt;
    logic [REG_AW-1:0] id_ex_regdest;
    logic [DATA_W-1:0] id_ex_rs_data;
    logic [DATA_W-1:0] id_ex_rt_data;
    logic [DATA_W-1:0] id_ex_imm;
    logic              stall_if_id;
    logic              flush_if_id;

    modport master (
        output id_valid, id_regrs, id_regrt, id_regdest, id_rs_used, id_rt_used,
               id_regwrite, id_memread, id_memwrite, id_rs_data, id_rt_data, id_imm,
               ex_flush, mem_busy,
        input  id_ex_valid, id_ex_regwrite, id_ex_memread, id_ex_memwrite,
               id_ex_regrs, id_ex_regrt, id_ex_regdest,
               id_ex_rs_data, id_ex_rt_data, id_ex_imm,
               stall_if_id, flush_if_id
    );

    modport slave (
        input  id_valid, id_regrs, id_regrt, id_regdest, id_rs_used, id_rt_used,
               id_regwrite, id_memread, id_memwrite, id_rs_data, id_rt_data, id_imm,
               ex_flush, mem_busy,
        output id_ex_valid, id_ex_regwrite, id_ex_memread, id_ex_memwrite,
               id_ex_regrs, id_ex_regrt, id_ex_regdest,
               id_ex_rs_data, id_ex_rt_data, id_ex_imm,
               stall_if_id, flush_if_id
    );

endinterface

// File: rtl/id_ex_hazard_reg_load_use_detect.sv
// Load-use detector: a load in EX whose destination is read by the instruction in ID.
// Purely combinational, zero latency; no flow control.
module load_use_detect
    import id_ex_hazard_reg_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              ex_valid,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_regdest,
    input  logic              id_valid,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic [REG_AW-1:0] id_regrs,
    input  logic [REG_AW-1:0] id_regrt,
    output logic              lu
);

    logic rs_hit;
    logic rt_hit;

    always_comb begin
        rs_hit = id_rs_used & (id_regrs == ex_regdest);
        rt_hit = id_rt_used & (id_regrt == ex_regdest);
        // R0 is hardwired zero, so a load targeting it never creates a dependency.
        lu     = ex_valid & ex_memread & (ex_regdest != REG_AW'(ZERO_REG)) &
                 id_valid & (rs_hit | rt_hit);
    end

endmodule

// File: rtl/id_ex_hazard_reg.sv
// ID/EX register with load-use stall, branch flush and memory freeze; 1-cycle id_* -> id_ex_* latency.
// mem_busy freezes ID/EX and stalls IF/ID; HAZ_PERF_CNT_EN adds saturating lu/flush/hold counters.
module id_ex_hazard_reg
    import id_ex_hazard_reg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    id_ex_hazard_reg_if.slave bus
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [15:0]       lu_stall_cnt,
    output logic [15:0]       flush_cnt,
    output logic [15:0]       hold_cnt
`endif
);

    typedef struct packed {
        ctrl_t             ctrl;
        logic [REG_AW-1:0] regrs;
        logic [REG_AW-1:0] regrt;
        logic [REG_AW-1:0] regdest;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
    } idex_t;

    state_e state_q, state_d;
    logic   flush_pend_q, flush_pend_d;
    idex_t  idex_q, idex_d;

    logic   lu;
    logic   eff_flush;
    logic   lu_case;
    logic   flush_case;
    logic   stall_if_id;
    logic   flush_if_id;
    idex_t  bubble;
    idex_t  capture;

    load_use_detect #(.REG_AW(REG_AW)) u_lu (
        .ex_valid   (idex_q.ctrl.valid),
        .ex_memread (idex_q.ctrl.memread),
        .ex_regdest (idex_q.regdest),
        .id_valid   (bus.id_valid),
        .id_rs_used (bus.id_rs_used),
        .id_rt_used (bus.id_rt_used),
        .id_regrs   (bus.id_regrs),
        .id_regrt   (bus.id_regrt),
        .lu         (lu)
    );

    always_comb begin
        bubble       = '0;
        bubble.ctrl  = BUBBLE_CTRL;

        capture.ctrl.valid    = 1'b1;
        capture.ctrl.regwrite = bus.id_regwrite;
        capture.ctrl.memread  = bus.id_memread;
        capture.ctrl.memwrite = bus.id_memwrite;
        capture.regrs         = bus.id_regrs;
        capture.regrt         = bus.id_regrt;
        capture.regdest       = bus.id_regdest;
        capture.rs_data       = bus.id_rs_data;
        capture.rt_data       = bus.id_rt_data;
        capture.imm           = bus.id_imm;
    end

    always_comb begin
        state_d      = state_q;
        flush_pend_d = flush_pend_q;
        idex_d       = idex_q;
        stall_if_id  = 1'b0;
        flush_if_id  = 1'b0;
        lu_case      = 1'b0;
        flush_case   = 1'b0;

        // A flush seen while frozen is replayed on the release cycle.
        eff_flush = bus.ex_flush | ((state_q == ST_HOLD) & flush_pend_q);

        if (bus.mem_busy) begin
            stall_if_id  = 1'b1;
            flush_pend_d = flush_pend_q | bus.ex_flush;
            state_d      = ST_HOLD;
        end else begin
            state_d      = ST_RUN;
            flush_pend_d = 1'b0;
            if (eff_flush) begin
                idex_d      = bubble;
                flush_if_id = 1'b1;
                flush_case  = 1'b1;
            end else if (lu) begin
                idex_d      = bubble;
                stall_if_id = 1'b1;
                lu_case     = 1'b1;
            end else if (bus.id_valid) begin
                idex_d = capture;
            end else begin
                idex_d = bubble;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            flush_pend_q <= 1'b0;
            idex_q       <= '0;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
            idex_q       <= idex_d;
        end
    end

    assign bus.id_ex_valid    = idex_q.ctrl.valid;
    assign bus.id_ex_regwrite = idex_q.ctrl.regwrite;
    assign bus.id_ex_memread  = idex_q.ctrl.memread;
    assign bus.id_ex_memwrite = idex_q.ctrl.memwrite;
    assign bus.id_ex_regrs    = idex_q.regrs;
    assign bus.id_ex_regrt    = idex_q.regrt;
    assign bus.id_ex_regdest  = idex_q.regdest;
    assign bus.id_ex_rs_data  = idex_q.rs_data;
    assign bus.id_ex_rt_data  = idex_q.rt_data;
    assign bus.id_ex_imm      = idex_q.imm;
    assign bus.stall_if_id    = stall_if_id;
    assign bus.flush_if_id    = flush_if_id;

`ifdef HAZ_PERF_CNT_EN
    logic [15:0] lu_stall_cnt_q, lu_stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic [15:0] hold_cnt_q, hold_cnt_d;

    always_comb begin
        lu_stall_cnt_d = lu_stall_cnt_q;
        flush_cnt_d    = flush_cnt_q;
        hold_cnt_d     = hold_cnt_q;
        if (lu_case)             lu_stall_cnt_d = sat_inc16(lu_stall_cnt_q);
        if (flush_case)          flush_cnt_d    = sat_inc16(flush_cnt_q);
        if (state_q == ST_HOLD)  hold_cnt_d     = sat_inc16(hold_cnt_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lu_stall_cnt_q <= '0;
            flush_cnt_q    <= '0;
            hold_cnt_q     <= '0;
        end else begin
            lu_stall_cnt_q <= lu_stall_cnt_d;
            flush_cnt_q    <= flush_cnt_d;
            hold_cnt_q     <= hold_cnt_d;
        end
    end

    assign lu_stall_cnt = lu_stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;
    assign hold_cnt     = hold_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Directed bench for id_ex_hazard_reg: load-use, R0/unused-operand cases, flush priority, freeze, reset in HOLD.
module tb_id_ex_hazard_reg;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    id_ex_hazard_reg_if bus ();

`ifdef HAZ_PERF_CNT_EN
    logic [15:0] lu_stall_cnt;
    logic [15:0] flush_cnt;
    logic [15:0] hold_cnt;
`endif

    id_ex_hazard_reg dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef HAZ_PERF_CNT_EN
        ,
        .lu_stall_cnt (lu_stall_cnt),
        .flush_cnt    (flush_cnt),
        .hold_cnt     (hold_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] rs, input logic [3:0] rt,
                         input logic [3:0] dest, input logic rs_u, input logic rt_u,
                         input logic rw, input logic mr, input logic mw,
                         input logic [15:0] rsd, input logic [15:0] rtd, input logic [15:0] imm);
        bus.id_valid    = v;
        bus.id_regrs    = rs;
        bus.id_regrt    = rt;
        bus.id_regdest  = dest;
        bus.id_rs_used  = rs_u;
        bus.id_rt_used  = rt_u;
        bus.id_regwrite = rw;
        bus.id_memread  = mr;
        bus.id_memwrite = mw;
        bus.id_rs_data  = rsd;
        bus.id_rt_data  = rtd;
        bus.id_imm      = imm;
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 4'd1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        bus.ex_flush = 1'b0;
        bus.mem_busy = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.id_ex_valid !== 1'b0 || bus.id_ex_regwrite !== 1'b0 || bus.id_ex_memread !== 1'b0 ||
            bus.id_ex_memwrite !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got v=%b rw=%b mr=%b mw=%b expected all 0", bus.id_ex_valid,
                     bus.id_ex_regwrite, bus.id_ex_memread, bus.id_ex_memwrite);
        end
        checks++;
        if (bus.id_ex_regdest !== 4'd0 || bus.id_ex_rs_data !== 16'h0 || bus.id_ex_imm !== 16'h0) begin
            errors++;
            $display("FAIL reset_data: got dest=%0h rs=%0h imm=%0h expected 0", bus.id_ex_regdest,
                     bus.id_ex_rs_data, bus.id_ex_imm);
        end
        rst = 1'b0;
        drive(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
        checks++;
        if (bus.stall_if_id !== 1'b0 || bus.flush_if_id !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall_flush: got stall=%b flush=%b expected 0/0", bus.stall_if_id, bus.flush_if_id);
        end
        tick();
    endtask

    task automatic test_id_valid_bubble();
        drive(1'b0, 4'd6, 4'd7, 4'd8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h5555, 16'h6666, 16'h7777);
        tick();
        checks++;
        if (bus.id_ex_valid !== 1'b0 || bus.id_ex_regdest !== 4'd0 || bus.id_ex_regwrite !== 1'b0 ||
            bus.id_ex_rs_data !== 16'h0) begin
            errors++;
            $display("FAIL invalid_bubble: got v=%b dest=%0h rw=%b rs=%0h expected 0/0/0/0", bus.id_ex_valid,
                     bus.id_ex_regdest, bus.id_ex_regwrite, bus.id_ex_rs_data);
        end
    endtask

    task automatic test_load_use();
        // LW R3, 4(R1)
        drive(1'b1, 4'd1, 4'd0, 4'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h1111, 16'h0, 16'h0004);
        checks++;
        if (bus.stall_if_id !== 1'b0) begin
            errors++;
            $display("FAIL lu_no_stall_before: got %b expected 0", bus.stall_if_id);
        end
        tick();
        checks++;
        if (bus.id_ex_valid !== 1'b1 || bus.id_ex_memread !== 1'b1 || bus.id_ex_regdest !== 4'd3 ||
            bus.id_ex_imm !== 16'h0004) begin
            errors++;
            $display("FAIL lw_capture: got v=%b mr=%b dest=%0h imm=%0h expected 1/1/3/4", bus.id_ex_valid,
                     bus.id_ex_memread, bus.id_ex_regdest, bus.id_ex_imm);
        end
        // ADD R4, R3, R5
        drive(1'b1, 4'd3, 4'd5, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'hAAAA, 16'hBBBB, 16'h0);
        checks++;
        if (bus.stall_if_id !== 1'b1 || bus.flush_if_id !== 1'b0) begin
            errors++;
            $display("FAIL lu_stall: got stall=%b flush=%b expected 1/0", bus.stall_if_id, bus.flush_if_id);
        end
        tick();
        checks++;
        if (bus.id_ex_valid !== 1'b0 || bus.id_ex_regdest !== 4'd0 || bus.id_ex_memread !== 1'b0) begin
            errors++;
            $display("FAIL lu_bubble: got v=%b dest=%0h mr=%b expected 0/0/0", bus.id_ex_valid,
                     bus.id_ex_regdest, bus.id_ex_memread);
        end
        checks++;
        if (bus.stall_if_id !== 1'b0) begin
            errors++;
            $display("FAIL lu_stall_one_cycle: got %b expected 0", bus.stall_if_id);
        end
        tick();
        checks++;
        if (bus.id_ex_valid !== 1'b1 || bus.id_ex_regrs !== 4'd3 || bus.id_ex_regrt !== 4'd5 ||
            bus.id_ex_regdest !== 4'd4 || bus.id_ex_rs_data !== 16'hAAAA || bus.id_ex_rt_data !== 16'hBBBB) begin
            errors++;
            $display("FAIL add_advance: got v=%b rs=%0h rt=%0h dest=%0h rsd=%0h rtd=%0h expected 1/3/5/4/aaaa/bbbb",
                     bus.id_ex_valid, bus.id_ex_regrs, bus.id_ex_regrt, bus.id_ex_regdest,
                     bus.id_ex_rs_data, bus.id_ex_rt_data);
        end
    endtask

    task automatic test_no_hazard();
        // LW R0 then a reader of R0
        drive(1'b1, 4'd2, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0008);
        tick();
        drive(1'b1, 4'd0, 4'd0, 4'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
        checks++;
        if (bus.stall_if_id !== 1'b0) begin
            errors++;
            $display("FAIL r0_no_stall: got %b expected 0", bus.stall_if_id);
        end
        tick();
        checks++;
        if (bus.id_ex_valid !== 1'b1 || bus.id_ex_regdest !== 4'd9) begin
            errors++;
            $display("FAIL r0_advance: got v=%b dest=%0h expected 1/9", bus.id_ex_valid, bus.id_ex_regdest);
        end
        // LW R3 then an instruction whose rt field is 3 but unused
        drive(1'b1, 4'd1, 4'd0, 4'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0);
        tick();
        drive(1'b1, 4'd2, 4'd3, 4'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h2222, 16'h3333, 16'h0010);
        checks++;
        if (bus.stall_if_id !== 1'b0) begin
            errors++;
            $display("FAIL rt_unused_no_stall: got %b expected 0", bus.stall_if_id);
        end
        tick();
        checks++;
        if (bus.id_ex_valid !== 1'b1 || bus.id_ex_regrt !== 4'd3 || bus.id_ex_imm !== 16'h0010) begin
            errors++;
            $display("FAIL rt_unused_advance: got v=%b rt=%0h imm=%0h expected 1/3/10", bus.id_ex_valid,
                     bus.id_ex_regrt, bus.id_ex_imm);
        end
    endtask

    task automatic test_flush_beats_lu();
        drive(1'b1, 4'd1, 4'd0, 4'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0);
        tick();
        drive(1'b1, 4'd3, 4'd5, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'hAAAA, 16'hBBBB, 16'h0);
        bus.ex_flush = 1'b1;
        #1;
        checks++;
        if (bus.flush_if_id !== 1'b1 || bus.stall_if_id !== 1'b0) begin
            errors++;
            $display("FAIL flush_priority: got flush=%b stall=%b expected 1/0", bus.flush_if_id, bus.stall_if_id);
        end
        tick();
        bus.ex_flush = 1'b0;
        checks++;
        if (bus.id_ex_valid !== 1'b0 || bus.id_ex_regwrite !== 1'b0 || bus.id_ex_regrs !== 4'd0) begin
            errors++;
            $display("FAIL flush_bubble: got v=%b rw=%b rs=%0h expected 0/0/0", bus.id_ex_valid,
                     bus.id_ex_regwrite, bus.id_ex_regrs);
        end
    endtask

    task automatic test_mem_busy_hold();
        drive(1'b1, 4'd1, 4'd2, 4'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h5678, 16'h0042);
        tick();
        drive(1'b1, 4'd8, 4'd9, 4'd10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'hCAFE, 16'hBEEF, 16'h0001);
        for (int c = 0; c < 3; c++) begin
            bus.mem_busy = 1'b1;
            bus.ex_flush = (c == 1);
            #1;
            checks++;
            if (bus.stall_if_id !== 1'b1 || bus.flush_if_id !== 1'b0) begin
                errors++;
                $display("FAIL busy_stall[%0d]: got stall=%b flush=%b expected 1/0", c,
                         bus.stall_if_id, bus.flush_if_id);
            end
            tick();
            checks++;
            if (bus.id_ex_valid !== 1'b1 || bus.id_ex_regdest !== 4'd7 || bus.id_ex_rs_data !== 16'h1234 ||
                bus.id_ex_imm !== 16'h0042) begin
                errors++;
                $display("FAIL busy_hold[%0d]: got v=%b dest=%0h rsd=%0h imm=%0h expected 1/7/1234/42", c,
                         bus.id_ex_valid, bus.id_ex_regdest, bus.id_ex_rs_data, bus.id_ex_imm);
            end
        end
        bus.mem_busy = 1'b0;
        bus.ex_flush = 1'b0;
        #1;
        checks++;
        if (bus.flush_if_id !== 1'b1 || bus.stall_if_id !== 1'b0) begin
            errors++;
            $display("FAIL release_flush: got flush=%b stall=%b expected 1/0", bus.flush_if_id, bus.stall_if_id);
        end
        tick();
        checks++;
        if (bus.id_ex_valid !== 1'b0 || bus.id_ex_regdest !== 4'd0) begin
            errors++;
            $display("FAIL release_bubble: got v=%b dest=%0h expected 0/0", bus.id_ex_valid, bus.id_ex_regdest);
        end
        checks++;
        if (bus.flush_if_id !== 1'b0) begin
            errors++;
            $display("FAIL pend_cleared: got flush=%b expected 0", bus.flush_if_id);
        end
        tick();
        checks++;
        if (bus.id_ex_valid !== 1'b1 || bus.id_ex_regdest !== 4'd10 || bus.id_ex_rs_data !== 16'hCAFE) begin
            errors++;
            $display("FAIL after_release: got v=%b dest=%0h rsd=%0h expected 1/a/cafe", bus.id_ex_valid,
                     bus.id_ex_regdest, bus.id_ex_rs_data);
        end
    endtask

    task automatic test_reset_in_hold();
        drive(1'b1, 4'd1, 4'd2, 4'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h1234, 16'h5678, 16'h0042);
        tick();
        bus.mem_busy = 1'b1;
        bus.ex_flush = 1'b1;
        tick();
        bus.ex_flush = 1'b0;
        rst = 1'b1;
        tick();
        checks++;
        if (bus.id_ex_valid !== 1'b0 || bus.id_ex_memread !== 1'b0 || bus.id_ex_regdest !== 4'd0 ||
            bus.id_ex_rs_data !== 16'h0) begin
            errors++;
            $display("FAIL hold_reset: got v=%b mr=%b dest=%0h rsd=%0h expected 0/0/0/0", bus.id_ex_valid,
                     bus.id_ex_memread, bus.id_ex_regdest, bus.id_ex_rs_data);
        end
        rst = 1'b0;
        bus.mem_busy = 1'b0;
        drive(1'b1, 4'd4, 4'd5, 4'd11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0BAD, 16'h0, 16'h0);
        checks++;
        if (bus.flush_if_id !== 1'b0 || bus.stall_if_id !== 1'b0) begin
            errors++;
            $display("FAIL no_pend_after_reset: got flush=%b stall=%b expected 0/0", bus.flush_if_id,
                     bus.stall_if_id);
        end
        tick();
        checks++;
        if (bus.id_ex_valid !== 1'b1 || bus.id_ex_regdest !== 4'd11) begin
            errors++;
            $display("FAIL run_after_reset: got v=%b dest=%0h expected 1/b", bus.id_ex_valid, bus.id_ex_regdest);
        end
    endtask

`ifdef HAZ_PERF_CNT_EN
    task automatic test_perf_counters();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b1, 4'd1, 4'd0, 4'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0);
        tick();
        drive(1'b1, 4'd3, 4'd5, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
        tick();
        tick();
        bus.ex_flush = 1'b1;
        tick();
        bus.ex_flush = 1'b0;
        bus.mem_busy = 1'b1;
        tick();
        tick();
        bus.mem_busy = 1'b0;
        tick();
        checks++;
        if (lu_stall_cnt !== 16'd1 || flush_cnt !== 16'd1 || hold_cnt !== 16'd2) begin
            errors++;
            $display("FAIL perf_counts: got lu=%0d fl=%0d hold=%0d expected 1/1/2", lu_stall_cnt, flush_cnt,
                     hold_cnt);
        end
    endtask
`endif

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        bus.ex_flush = 1'b0;
        bus.mem_busy = 1'b0;
        test_reset();
        test_id_valid_bubble();
        test_load_use();
        test_no_hazard();
        test_flush_beats_lu();
        test_mem_busy_hold();
        test_reset_in_hold();
`ifdef HAZ_PERF_CNT_EN
        test_perf_counters();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
